// File: rtl/bp_update_scheduler.sv
// Single write-point sequencer for the gshare predictor: resolves mispredicts into a
// registered flush/redirect, queues table updates, and runs the table-init sweep.
module bp_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5,
  parameter int TAG_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_is_branch,
  input  logic             res_is_jal,
  input  logic             res_is_jalr,
  input  logic [31:0]      res_pc,
  input  logic [IDX_W-1:0] res_pht_index,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  input  logic             res_actual_taken,
  input  logic [31:0]      res_actual_target,
  input  logic             clear_req,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_pht_index,
  output logic             upd_taken,
  output logic             upd_btb_we,
  output logic [IDX_W-1:0] upd_btb_index,
  output logic [TAG_W-1:0] upd_tag,
  output logic [31:0]      upd_target,
  output logic             upd_bhsr_shift,
  output logic             init_we,
  output logic [IDX_W-1:0] init_index,
  output logic             busy,
  output logic [15:0]      mispred_cnt,
  output logic [1:0]       state_dbg
);

  // Handshakes: a resolution transfers on a rising edge where res_valid && res_ready;
  // an update transfers where upd_valid && upd_ready, and the head stays stable until then.

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] pht_index;
    logic             taken;
    logic             btb_we;
    logic [IDX_W-1:0] btb_index;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             bhsr_shift;
  } upd_t;

  state_t           state, state_nxt;
  upd_t             fifo_mem [DEPTH];
  upd_t             new_entry, shown;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, is_cf, accept, push, pop, mispred, drained;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign is_cf   = res_is_branch | res_is_jal | res_is_jalr;
  assign accept  = res_valid & res_ready;
  assign push    = accept & is_cf;
  assign pop     = upd_valid & upd_ready;
  assign mispred = (res_pred_taken != res_actual_taken) ||
                   (res_actual_taken && (res_pred_target != res_actual_target));
  // No push can happen outside RUN-without-clear, so only the pop matters here.
  assign drained = empty || ((count == ONE_CNT) && pop);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_index == LAST_IDX) state_nxt = S_RUN;
      S_RUN:   if (clear_req) state_nxt = drained ? S_INIT : S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_INIT;
      default: state_nxt = S_INIT;
    endcase
  end

  // Output decode
  always_comb begin
    res_ready = 1'b0;
    upd_valid = 1'b0;
    init_we   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_INIT: init_we = 1'b1;
      S_RUN: begin
        res_ready = !full && !clear_req;
        upd_valid = !empty;
        busy      = 1'b0;
      end
      S_DRAIN: upd_valid = !empty;
      default: ;
    endcase
  end

  assign state_dbg = state;

  // Sweep index wraps to 0 after the last entry, ready for the next sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                init_index <= '0;
    else if (state == S_INIT) init_index <= init_index + 1'b1;
    else                      init_index <= '0;
  end

  always_comb begin
    new_entry.pht_index  = res_pht_index;
    new_entry.taken      = res_actual_taken;
    new_entry.btb_we     = mispred && (res_is_jal || res_is_jalr ||
                                       (res_is_branch && res_actual_taken));
    new_entry.btb_index  = res_pc[IDX_W+1:2];
    new_entry.tag        = res_pc[31:32-TAG_W];
    new_entry.target     = res_actual_target;
    new_entry.bhsr_shift = res_is_branch;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Outputs read as zero whenever no update is being presented.
  assign shown = upd_valid ? fifo_mem[rd_ptr] : '0;

  assign upd_pht_index  = shown.pht_index;
  assign upd_taken      = shown.taken;
  assign upd_btb_we     = shown.btb_we;
  assign upd_btb_index  = shown.btb_index;
  assign upd_tag        = shown.tag;
  assign upd_target     = shown.target;
  assign upd_bhsr_shift = shown.bhsr_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      mispred_cnt <= '0;
    end else begin
      flush <= push && mispred;
      if (push && mispred) begin
        redirect_pc <= res_actual_taken ? res_actual_target : res_pc + 32'd4;
        if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sequences all writes into the gshare predictor (PHT counters, BTB targets, BTB tags, BHSR) from one point.
- Sits between EX-stage branch resolution and the predictor's single write port.
- Accepts resolved control-flow results, detects misprediction, and issues a registered flush/redirect to fetch.
- Queues predictor updates in a small FIFO and drains them one per cycle under a ready handshake; also runs the post-reset/software table-initialisation sweep.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, >=2).
- IDX_W, 5, PHT/BTB index width; tables have 2**IDX_W entries.
- TAG_W, 25, BTB tag width (res_pc[31:32-TAG_W]).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; everything below returns to reset values immediately.
- res_valid  in  1  resolution present from EX.
- res_ready  out  1  scheduler can accept a resolution this cycle.
- res_is_branch / res_is_jal / res_is_jalr  in  1 each  instruction class; at most one high.
- res_pc  in  32  PC of resolved instruction.
- res_pht_index  in  IDX_W  PHT index used at prediction time.
- res_pred_taken  in  1  predicted direction.
- res_pred_target  in  32  predicted next PC.
- res_actual_taken  in  1  actual direction (1 for jal/jalr).
- res_actual_target  in  32  actual taken target.
- clear_req  in  1  one-cycle pulse: re-initialise predictor tables.
- flush  out  1  squash younger instructions.
- redirect_pc  out  32  fetch restart PC, valid while flush=1.
- upd_valid  out  1  FIFO head update presented.
- upd_ready  in  1  predictor accepts update.
- upd_pht_index  out  IDX_W  counter to bump.
- upd_taken  out  1  increment (1) / decrement (0).
- upd_btb_we  out  1  write BTB entry + tag.
- upd_btb_index  out  IDX_W  res_pc[IDX_W+1:2].
- upd_tag  out  TAG_W  res_pc[31:32-TAG_W].
- upd_target  out  32  actual target.
- upd_bhsr_shift  out  1  shift upd_taken into BHSR (conditional branches only).
- init_we  out  1  table-initialisation write strobe.
- init_index  out  IDX_W  entry being initialised (PHT<=2'b11, tag<=all-ones, BTB<=0).
- busy  out  1  state != RUN.
- mispred_cnt  out  16  saturating mispredict counter.

Behaviour:
- Reset values: state=INIT, init_index=0, FIFO empty, flush=0, redirect_pc=0, mispred_cnt=0, all upd_* outputs 0.
- States:
  - INIT: init_we=1 every cycle, init_index increments 0..2**IDX_W-1. After the write at the last index, go to RUN (32 cycles at default).
  - RUN: normal operation.
  - DRAIN: entered from RUN on clear_req. Accepts nothing. Goes to INIT (init_index=0) in the cycle the FIFO becomes empty, or immediately if it is already empty.
- res_ready = (state==RUN) && !full && !clear_req. No simultaneous enqueue while full, even with a dequeue.
- Accept = res_valid && res_ready.
  - Non-control-flow resolutions (all class bits 0) are accepted and ignored.
- Correct when: res_pred_taken==res_actual_taken && (!res_actual_taken || res_pred_target==res_actual_target).
- On an accepted mispredict at cycle N:
  - flush=1 for exactly cycle N+1.
  - redirect_pc = res_actual_taken ? res_actual_target : res_pc+4 (32-bit wrap).
  - mispred_cnt increments and saturates at 16'hFFFF.
- Enqueue on every accepted control-flow resolution. Stored fields:
  - pht_index.
  - taken = actual_taken.
  - btb_we = mispredicted && (jal||jalr||(branch && actual_taken)).
  - btb index, tag, target.
  - bhsr_shift = is_branch.
- Dequeue: upd_valid = !empty && state!=INIT; pop when upd_valid && upd_ready.
  - upd_* are driven from the FIFO head; they are held stable while upd_valid && !upd_ready.
  - An enqueue at cycle N is visible at the head no earlier than N+1.
- Simultaneous push and pop: count unchanged, pointers wrap modulo DEPTH.
- clear_req outside RUN is ignored.
- A flush pending in the FIFO does not block flush generation.
- Asynchronous reset mid-INIT or mid-DRAIN: queued updates are discarded and the sweep restarts at index 0.

Test Plan:
- Release reset -> busy=1, init_we pulses with init_index 0..31 over 32 cycles, then busy=0 and res_ready=1 at cycle 33.
- Accept a branch at pc=0x100, pred_taken=0, actual_taken=1, target=0x140 -> next cycle flush=1, redirect_pc=0x140; head upd_btb_we=1, upd_btb_index=0, upd_tag=0x2, upd_taken=1, upd_bhsr_shift=1; mispred_cnt=1.
- Accept a correct not-taken branch at pc=0x204 -> no flush, upd_btb_we=0, upd_taken=0; jalr mispredict with actual target 0x80 -> redirect_pc=0x80, upd_bhsr_shift=0.
- Hold upd_ready=0 and send 4 resolutions -> res_ready drops after the 4th, head fields stay stable; raise upd_ready -> 4 pops in order on consecutive cycles, then res_ready=1.
- Pulse clear_req with 2 queued entries -> DRAIN until both pop, then a 32-cycle INIT sweep; res_valid is ignored throughout.
- Assert reset during DRAIN with entries queued -> upd_valid=0, flush=0, mispred_cnt=0 immediately; sweep restarts at init_index=0.
